disparity_qualifier_fifo: RTL and testbench

- Sits directly downstream of the minimum-distance finder. Consumes one winning match per reference block.
- Scores each match for confidence and uniqueness, and replaces weak or invalid matches with a fixed invalid code.
- Buffers qualified results in a small first-word-fall-through FIFO and streams them to the result writer over valid/ready.
- Decouples back-pressure in the writer from the free-running matcher; drops and counts results on overflow.

---
 rtl/bm_pkg.sv | 21 ++
 rtl/disparity_qualifier_fifo_if.sv | 25 ++
 rtl/sync_fwft_fifo.sv | 53 +++++
 rtl/disparity_qualifier_fifo.sv | 101 ++++++++++
 tb/tb_disparity_qualifier_fifo.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bm_pkg.sv
// Shared types and constants for the block-matching result path.
// Holds the qualified-result layout and the frame/invalid markers.
package bm_pkg;

    typedef struct packed {
        logic [15:0] blk_index;
        logic [7:0]  disp;
        logic [7:0]  confidence;
    } disp_result_t;

    localparam logic [15:0] INVALID_COORDS = 16'hFFFF;
    localparam logic [11:0] FRAME_IDX_MASK = 12'hFFF;

    function automatic logic [7:0] sat_sub(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a > b) ? a - b : 8'd0;
    endfunction

endpackage

// File: rtl/disparity_qualifier_fifo_if.sv
// Result stream toward the writer.
// First-word-fall-through head with valid/ready handshake.
interface disparity_qualifier_fifo_if;
    import bm_pkg::*;

    disp_result_t out_data;
    logic         out_sof;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_sof,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sof,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Occupancy counter decides full/empty; pointers wrap modulo DEPTH.
module sync_fwft_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; written only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW+1)'(1);
            else if (do_pop && !do_push)
                level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/disparity_qualifier_fifo.sv
// Scores each winning match, rejects weak ones and buffers
// the qualified results for the writer; counts overflow drops.
module disparity_qualifier_fifo #(
    parameter int          DEPTH        = 16,
    parameter logic [7:0]  INVALID_DISP = 8'hFF,
    parameter int          CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             min_sum,
    input  logic [7:0]             min_sumh,
    input  logic [7:0]             average_sum,
    input  logic [15:0]            min_out_coords,
    input  logic [15:0]            min_blk_index_o,
    input  logic                   min_sum_valid,
    input  logic [7:0]             conf_thresh,
    input  logic [7:0]             uniq_thresh,
    disparity_qualifier_fifo_if.master res,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    import bm_pkg::*;

    disp_result_t cap;
    logic         cap_sof;
    disp_result_t s1_res;
    logic         s1_sof;
    logic         s1_valid;
    logic [7:0]   conf;
    logic [7:0]   uniq;
    logic         reject;
    logic         pop;
    logic         full;
    logic         empty;
    logic         drop;
    logic [32:0]  head;

    // Confidence/uniqueness scoring and result formatting.
    always_comb begin
        conf   = sat_sub(average_sum, min_sum);
        uniq   = sat_sub(min_sumh, min_sum);
        reject = (min_out_coords == INVALID_COORDS) |
                 (conf < conf_thresh) |
                 (uniq < uniq_thresh);
        cap.blk_index  = min_blk_index_o;
        cap.disp       = reject ? INVALID_DISP : min_out_coords[7:0];
        cap.confidence = conf;
        cap_sof = ((min_blk_index_o[11:0] & FRAME_IDX_MASK) == 12'd0);
    end

    // Stage 1 register; never stalls the matcher.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_sof   <= 1'b0;
        end else begin
            s1_valid <= min_sum_valid;
            if (min_sum_valid) begin
                s1_res <= cap;
                s1_sof <= cap_sof;
            end
        end
    end

    assign pop  = res.out_valid & res.out_ready;
    assign drop = s1_valid & full & ~pop;

    sync_fwft_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid),
        .din   ({s1_sof, s1_res}),
        .pop   (pop),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign res.out_valid = ~empty;
    assign res.out_sof   = head[32];
    assign res.out_data  = head[31:0];

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_disparity_qualifier_fifo.sv
// Directed bench for disparity_qualifier_fifo.
// Hand-computed vectors, checked with immediate assertions.
module tb_disparity_qualifier_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  min_sum = '0;
    logic [7:0]  min_sumh = '0;
    logic [7:0]  average_sum = '0;
    logic [15:0] min_out_coords = '0;
    logic [15:0] min_blk_index_o = '0;
    logic        min_sum_valid = 1'b0;
    logic [7:0]  conf_thresh = 8'd20;
    logic [7:0]  uniq_thresh = 8'd8;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;

    disparity_qualifier_fifo_if res_if ();

    disparity_qualifier_fifo #(
        .DEPTH        (DEPTH),
        .INVALID_DISP (8'hFF),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .min_sum         (min_sum),
        .min_sumh        (min_sumh),
        .average_sum     (average_sum),
        .min_out_coords  (min_out_coords),
        .min_blk_index_o (min_blk_index_o),
        .min_sum_valid   (min_sum_valid),
        .conf_thresh     (conf_thresh),
        .uniq_thresh     (uniq_thresh),
        .res             (res_if),
        .overflow        (overflow),
        .drop_count      (drop_count),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ms, input logic [7:0] msh,
                         input logic [7:0] avg, input logic [15:0] crd,
                         input logic [15:0] blk);
        min_sum         = ms;
        min_sumh        = msh;
        average_sum     = avg;
        min_out_coords  = crd;
        min_blk_index_o = blk;
        min_sum_valid   = 1'b1;
    endtask

    task automatic single(input string tag, input logic [7:0] ms,
                          input logic [7:0] msh, input logic [7:0] avg,
                          input logic [15:0] crd, input logic [15:0] blk,
                          input logic [31:0] exp_data,
                          input logic exp_sof);
        drive(ms, msh, avg, crd, blk);
        @(negedge clk);
        min_sum_valid = 1'b0;
        chk({tag, "_n1_valid"}, 32'(res_if.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_n2_valid"}, 32'(res_if.out_valid), 32'd1);
        chk({tag, "_data"}, res_if.out_data, exp_data);
        chk({tag, "_sof"}, 32'(res_if.out_sof), 32'(exp_sof));
        res_if.out_ready = 1'b1;
        @(negedge clk);
        res_if.out_ready = 1'b0;
        chk({tag, "_popped"}, 32'(res_if.out_valid), 32'd0);
    endtask

    initial begin
        res_if.out_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(res_if.out_valid), 32'd0);
        chk("rst_data", res_if.out_data, 32'd0);
        chk("rst_sof", 32'(res_if.out_sof), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        #12 reset = 1'b1;
        @(negedge clk);

        single("good", 8'd10, 8'd40, 8'd100, 16'h0023, 16'h0005,
               32'h0005_23_5A, 1'b0);
        single("lowconf", 8'd10, 8'd40, 8'd25, 16'h0023, 16'h0005,
               32'h0005_FF_0F, 1'b0);
        single("satconf", 8'd30, 8'd40, 8'd25, 16'h0023, 16'h0005,
               32'h0005_FF_00, 1'b0);
        single("invsof", 8'd10, 8'd40, 8'd100, 16'hFFFF, 16'h3000,
               32'h3000_FF_5A, 1'b1);
        single("lowuniq", 8'd10, 8'd15, 8'd100, 16'h0042, 16'h1001,
               32'h1001_FF_5A, 1'b0);

        for (int i = 0; i < DEPTH + 3; i++) begin
            drive(8'd10, 8'd40, 8'd100, 16'(i), 16'(i + 1));
            @(negedge clk);
        end
        min_sum_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd3);
        res_if.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_drain_valid", 32'(res_if.out_valid), 32'd1);
            chk("ovf_drain_data", res_if.out_data,
                {16'(i + 1), 8'(i), 8'h5A});
            @(negedge clk);
        end
        res_if.out_ready = 1'b0;
        chk("ovf_empty", 32'(res_if.out_valid), 32'd0);
        chk("ovf_level0", 32'(fifo_level), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            drive(8'd10, 8'd40, 8'd100, 16'(i), 16'h0100 + 16'(i));
            @(negedge clk);
        end
        min_sum_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pp_full", 32'(fifo_level), 32'(DEPTH));
        drive(8'd10, 8'd40, 8'd100, 16'h0077, 16'h0200);
        @(negedge clk);
        min_sum_valid = 1'b0;
        res_if.out_ready = 1'b1;
        @(negedge clk);
        res_if.out_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 32'(DEPTH));
        chk("pp_drops", 32'(drop_count), 32'd3);
        res_if.out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            chk("pp_drain", res_if.out_data,
                {16'h0100 + 16'(i), 8'(i), 8'h5A});
            @(negedge clk);
        end
        chk("pp_last", res_if.out_data, 32'h0200_77_5A);
        @(negedge clk);
        res_if.out_ready = 1'b0;
        chk("pp_empty", 32'(res_if.out_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(8'd10, 8'd40, 8'd100, 16'(i), 16'h0300 + 16'(i));
            @(negedge clk);
        end
        min_sum_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_level5", 32'(fifo_level), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(res_if.out_valid), 32'd0);
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_drops", 32'(drop_count), 32'd0);
        chk("ar_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        single("post_rst", 8'd5, 8'd50, 8'd60, 16'h0011, 16'h0007,
               32'h0007_11_37, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
